button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_pkg.sv | 21 ++
 rtl/sync_ff.sv | 32 +++
 rtl/button_debouncer.sv | 126 ++++++++++++
 tb/tb_button_debouncer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// ============================================================================
// button_debouncer_pkg : shared FSM state type and default parameters
// Revision: 1.0
// ============================================================================
`default_nettype none

package button_debouncer_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

endpackage : button_debouncer_pkg

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// sync_ff : STAGES-deep flip-flop synchronizer, async active-low reset to 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_ff
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : sync_ff

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// button_debouncer : synchronize, debounce and pulse on each accepted press.
// Optional macro BUTTON_DEBOUNCER_RELEASE_PULSE_EN adds output button_released.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  output logic button_released,
`endif
  output logic button_out
);

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             button_sync;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_nxt;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  logic             release_nxt;
`endif

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_in),
    .q     (button_sync)
  );

  // Saturating increment: the counter can never wrap past DEBOUNCE_CYCLES.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    release_nxt = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (button_sync) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!button_sync) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (!button_sync) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (button_sync) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
          release_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      button_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      button_out <= press_nxt;
    end
  end

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      button_released <= 1'b0;
    end else begin
      button_released <= release_nxt;
    end
  end
`endif

endmodule : button_debouncer

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// tb_button_debouncer : randomized scoreboard bench for button_debouncer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic button_in = 1'b0;
  logic button_out;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
  logic button_released;
`endif

  int compared   = 0;
  int mismatched = 0;
  int edge_cnt   = 0;

  // Scoreboard: edge numbers after which a pulse is expected.
  int press_q[$];
  int rel_q[$];

  // Reference model: raw sample history, debounced level, run length.
  bit hist[$];
  bit stable = 1'b0;
  int run    = 0;

  bit exp_p;
  bit exp_r;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .button_in       (button_in),
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    .button_released (button_released),
`endif
    .button_out      (button_out)
  );

  // The level seen after synchronization is the raw level S edges ago; a
  // change is accepted once it has been seen on D+1 consecutive edges.
  task automatic model_edge(input bit b);
    bit s;
    hist.push_back(b);
    if (hist.size() > S + 1) void'(hist.pop_front());
    s   = (hist.size() == S + 1) ? hist[0] : 1'b0;
    run = (s != stable) ? run + 1 : 0;
    if (run == D + 1) begin
      stable = s;
      run    = 0;
      if (s) press_q.push_back(edge_cnt);
      else   rel_q.push_back(edge_cnt);
    end
  endtask

  task automatic step(input bit b);
    @(negedge clk);
    button_in = b;
    @(posedge clk);
    edge_cnt++;
    model_edge(b);
  endtask

  task automatic hold(input bit b, input int n);
    repeat (n) step(b);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    hist.delete();
    press_q.delete();
    rel_q.delete();
    stable = 1'b0;
    run    = 0;
    repeat (n) begin
      @(posedge clk);
      edge_cnt++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    edge_cnt++;
    model_edge(button_in);
  endtask

  // Monitor: sample outputs 2 time units after every rising edge.
  always @(posedge clk) begin
    #2;
    if (edge_cnt > 0) begin
      exp_p = (press_q.size() > 0) && (press_q[0] == edge_cnt);
      compared++;
      if (button_out !== exp_p) begin
        mismatched++;
        $display("FAIL button_out edge %0d: got %b expected %b", edge_cnt, button_out, exp_p);
      end
      while (press_q.size() > 0 && press_q[0] <= edge_cnt) void'(press_q.pop_front());
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
      exp_r = (rel_q.size() > 0) && (rel_q[0] == edge_cnt);
      compared++;
      if (button_released !== exp_r) begin
        mismatched++;
        $display("FAIL button_released edge %0d: got %b expected %b", edge_cnt, button_released, exp_r);
      end
`endif
      while (rel_q.size() > 0 && rel_q[0] <= edge_cnt) void'(rel_q.pop_front());
    end
  end

  initial begin
    do_reset(3);
    hold(0, 5);
    // clean press and release
    hold(1, 12);
    hold(0, 10);
    // bounce: never accepted
    hold(1, 3); hold(0, 1); hold(1, 3); hold(0, 10);
    // press, release, re-press
    hold(1, 10); hold(0, 6); hold(1, 10);
    // short release glitch while pressed
    hold(0, 2); hold(1, 10); hold(0, 10);
    // reset in the middle of a press, button held through release
    hold(1, 3);
    do_reset(2);
    hold(1, 12);
    hold(0, 10);
    // press held then released (release pulse path)
    hold(1, 10); hold(0, 10);
    // randomized runs of random length with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
      hold(bit'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    hold(0, 20);
    @(negedge clk);
    compared++;
    if (press_q.size() != 0) begin
      mismatched++;
      $display("FAIL press_drain: got %0d pending expected 0", press_q.size());
    end
    compared++;
    if (rel_q.size() != 0) begin
      mismatched++;
      $display("FAIL release_drain: got %0d pending expected 0", rel_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_button_debouncer

`default_nettype wire
